// File: rtl/dct_sau_pkg.sv
// Shared definitions for the odd-part shift-add multiplier bank of the 1-D DCT-II.
//   mode_e     : transform size select carried with every sample
//   NLANES     : number of product lanes per sample
//   COEF_N*    : odd coefficients per transform size, lane 0 first; unused
//                lanes are 0. The RTL never multiplies by these; they describe
//                the intended products for anyone modelling the block.
package dct_sau_pkg;

    typedef enum logic [1:0] {
        MODE_N4   = 2'd0,
        MODE_N8   = 2'd1,
        MODE_N16  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    localparam int NLANES = 8;

    localparam int COEF_N4  [NLANES] = '{36, 83, 0, 0, 0, 0, 0, 0};
    localparam int COEF_N8  [NLANES] = '{18, 50, 75, 89, 0, 0, 0, 0};
    localparam int COEF_N16 [NLANES] = '{9, 25, 43, 57, 70, 80, 87, 90};

endpackage

// File: rtl/sau_odd_terms.sv
// Combinational shift-add network producing all 14 distinct odd-DCT products
// of one sample. The sample arrives pre-expanded into the shared base terms
// x*1, x*4, x*8, x*9, x*16, x*32 (all sign-extended to W bits) so that the
// pipeline can register those terms between the two halves of the work.
//   x1..x32 : base terms of the sample
//   p9..p90 : x multiplied by 9, 18, 25, 36, 43, 50, 57, 70, 75, 80, 83, 87, 89, 90
module sau_odd_terms #(
    parameter int W = 27
) (
    input  logic signed [W-1:0] x1,
    input  logic signed [W-1:0] x4,
    input  logic signed [W-1:0] x8,
    input  logic signed [W-1:0] x9,
    input  logic signed [W-1:0] x16,
    input  logic signed [W-1:0] x32,
    output logic signed [W-1:0] p9,
    output logic signed [W-1:0] p18,
    output logic signed [W-1:0] p25,
    output logic signed [W-1:0] p36,
    output logic signed [W-1:0] p43,
    output logic signed [W-1:0] p50,
    output logic signed [W-1:0] p57,
    output logic signed [W-1:0] p70,
    output logic signed [W-1:0] p75,
    output logic signed [W-1:0] p80,
    output logic signed [W-1:0] p83,
    output logic signed [W-1:0] p87,
    output logic signed [W-1:0] p89,
    output logic signed [W-1:0] p90
);

    logic signed [W-1:0] p35;

    // Products are reused as partial terms wherever possible so that the
    // whole set costs only a handful of adders.
    assign p9  = x9;
    assign p18 = x9 <<< 1;
    assign p36 = x9 <<< 2;
    assign p25 = x16 + x9;
    assign p50 = p25 <<< 1;
    assign p75 = p50 + p25;
    assign p43 = x32 + x9 + (x1 <<< 1);
    assign p57 = x32 + p25;
    assign p35 = x32 + x4 - x1;
    assign p70 = p35 <<< 1;
    assign p80 = (x16 + x4) <<< 2;
    assign p83 = p75 + x8;
    assign p87 = p80 + x8 - x1;
    assign p89 = p80 + x9;
    assign p90 = (x9 <<< 3) + p18;

endmodule

// File: rtl/sau_odd_pipe.sv
// Pipelined multi-mode shift-add multiplier bank for the odd half of the
// 1-D DCT-II. Each accepted sample is multiplied by the odd coefficients of
// the selected transform size and presented as 8 signed lanes.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input handshake; in_mode selects N4/N8/N16 (3 reserved)
//   in_x                 : signed input sample
//   out_valid/out_ready  : output handshake
//   out_mode, out_err    : mode carried with the sample, reserved-mode flag
//   out_p                : 8 lanes, lane k at [k*OUT_W +: OUT_W]
// STAGES=2 registers the base terms first, then the final adds and lane mux.
// STAGES=1 keeps everything in front of the output register.
module sau_odd_pipe
    import dct_sau_pkg::*;
#(
    parameter int IN_W   = 18,
    parameter int OUT_W  = 27,
    parameter int STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              in_mode,
    input  logic [IN_W-1:0]         in_x,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              out_mode,
    output logic                    out_err,
    output logic [NLANES*OUT_W-1:0] out_p
);

    localparam int EXT = OUT_W - IN_W;

    // Base terms formed straight from the input sample
    logic signed [OUT_W-1:0] x1_next, x4_next, x8_next, x9_next, x16_next, x32_next;

    // Terms, mode and valid feeding the final stage (registered or direct)
    logic signed [OUT_W-1:0] t_x1, t_x4, t_x8, t_x9, t_x16, t_x32;
    logic [1:0]              t_mode;
    logic                    t_valid;

    logic signed [OUT_W-1:0] p9, p18, p25, p36, p43, p50, p57;
    logic signed [OUT_W-1:0] p70, p75, p80, p83, p87, p89, p90;

    logic signed [OUT_W-1:0] lane_next [NLANES];
    logic                    err_next;

    logic                    out_valid_reg;
    logic [1:0]              out_mode_reg;
    logic                    out_err_reg;
    logic signed [OUT_W-1:0] lane_reg [NLANES];

    // Output register can take new data when empty or being drained.
    logic adv_out;
    assign adv_out = !out_valid_reg || out_ready;

    assign x1_next  = {{EXT{in_x[IN_W-1]}}, in_x};
    assign x4_next  = x1_next <<< 2;
    assign x8_next  = x1_next <<< 3;
    assign x9_next  = x8_next + x1_next;
    assign x16_next = x1_next <<< 4;
    assign x32_next = x1_next <<< 5;

    generate
        if (STAGES == 2) begin : g_two
            logic                    v1_reg;
            logic [1:0]              mode1_reg;
            logic signed [OUT_W-1:0] x1_reg, x4_reg, x8_reg, x9_reg, x16_reg, x32_reg;

            // Stage 1 is free when empty or when its contents move on.
            assign in_ready = !v1_reg || adv_out;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v1_reg    <= 1'b0;
                    mode1_reg <= 2'd0;
                    x1_reg    <= '0;
                    x4_reg    <= '0;
                    x8_reg    <= '0;
                    x9_reg    <= '0;
                    x16_reg   <= '0;
                    x32_reg   <= '0;
                end else if (in_ready) begin
                    v1_reg <= in_valid;
                    if (in_valid) begin
                        mode1_reg <= in_mode;
                        x1_reg    <= x1_next;
                        x4_reg    <= x4_next;
                        x8_reg    <= x8_next;
                        x9_reg    <= x9_next;
                        x16_reg   <= x16_next;
                        x32_reg   <= x32_next;
                    end
                end
            end

            assign t_valid = v1_reg;
            assign t_mode  = mode1_reg;
            assign t_x1    = x1_reg;
            assign t_x4    = x4_reg;
            assign t_x8    = x8_reg;
            assign t_x9    = x9_reg;
            assign t_x16   = x16_reg;
            assign t_x32   = x32_reg;
        end else begin : g_one
            assign in_ready = adv_out;
            assign t_valid  = in_valid;
            assign t_mode   = in_mode;
            assign t_x1     = x1_next;
            assign t_x4     = x4_next;
            assign t_x8     = x8_next;
            assign t_x9     = x9_next;
            assign t_x16    = x16_next;
            assign t_x32    = x32_next;
        end
    endgenerate

    sau_odd_terms #(
        .W (OUT_W)
    ) u_terms (
        .x1  (t_x1),
        .x4  (t_x4),
        .x8  (t_x8),
        .x9  (t_x9),
        .x16 (t_x16),
        .x32 (t_x32),
        .p9  (p9),
        .p18 (p18),
        .p25 (p25),
        .p36 (p36),
        .p43 (p43),
        .p50 (p50),
        .p57 (p57),
        .p70 (p70),
        .p75 (p75),
        .p80 (p80),
        .p83 (p83),
        .p87 (p87),
        .p89 (p89),
        .p90 (p90)
    );

    // Per-mode lane selection; unused lanes and the reserved mode give 0.
    always_comb begin
        for (int k = 0; k < NLANES; k++) begin
            lane_next[k] = '0;
        end
        err_next = 1'b0;
        case (mode_e'(t_mode))
            MODE_N4: begin
                lane_next[0] = p36;
                lane_next[1] = p83;
            end
            MODE_N8: begin
                lane_next[0] = p18;
                lane_next[1] = p50;
                lane_next[2] = p75;
                lane_next[3] = p89;
            end
            MODE_N16: begin
                lane_next[0] = p9;
                lane_next[1] = p25;
                lane_next[2] = p43;
                lane_next[3] = p57;
                lane_next[4] = p70;
                lane_next[5] = p80;
                lane_next[6] = p87;
                lane_next[7] = p90;
            end
            default: begin
                err_next = 1'b1;
            end
        endcase
    end

    // Payload only loads with a real sample, so it holds steady while
    // stalled and never picks up bubble data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_mode_reg  <= 2'd0;
            out_err_reg   <= 1'b0;
            for (int k = 0; k < NLANES; k++) begin
                lane_reg[k] <= '0;
            end
        end else if (adv_out) begin
            out_valid_reg <= t_valid;
            if (t_valid) begin
                out_mode_reg <= t_mode;
                out_err_reg  <= err_next;
                for (int k = 0; k < NLANES; k++) begin
                    lane_reg[k] <= lane_next[k];
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_mode  = out_mode_reg;
    assign out_err   = out_err_reg;

    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_pack
            assign out_p[gi*OUT_W +: OUT_W] = lane_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_sau_odd_pipe.sv
// Self-checking bench for sau_odd_pipe: the driver pushes the expected
// product vector for every accepted sample into a queue, and a monitor pops
// and compares whenever the DUT hands a sample downstream.
module tb_sau_odd_pipe;
    import dct_sau_pkg::*;

    localparam int IN_W   = 18;
    localparam int OUT_W  = 27;
    localparam int STAGES = 2;
    localparam int PW     = NLANES * OUT_W;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mode;
    logic [IN_W-1:0] in_x;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_mode;
    logic          out_err;
    logic [PW-1:0] out_p;

    sau_odd_pipe #(
        .IN_W   (IN_W),
        .OUT_W  (OUT_W),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_err   (out_err),
        .out_p     (out_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    mode;
        logic          err;
        logic [PW-1:0] p;
        int            acc;
        bit            lat;
    } item_t;

    item_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    bit    lat_chk = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: x times each lane coefficient, wrapped to the lane width.
    function automatic logic [PW-1:0] model(input logic [1:0] m, input logic signed [IN_W-1:0] x);
        logic [PW-1:0] r;
        longint c;
        longint prod;
        r = '0;
        for (int k = 0; k < NLANES; k++) begin
            case (m)
                2'd0:    c = COEF_N4[k];
                2'd1:    c = COEF_N8[k];
                2'd2:    c = COEF_N16[k];
                default: c = 0;
            endcase
            prod = longint'(x) * c;
            r[k*OUT_W +: OUT_W] = prod[OUT_W-1:0];
        end
        return r;
    endfunction

    // One clock of stimulus; starts and ends just after a rising edge.
    task automatic drive(input logic v, input logic [1:0] m, input logic [IN_W-1:0] x,
                         input logic r, output bit acc);
        item_t it;
        in_valid  = v;
        in_mode   = m;
        in_x      = x;
        out_ready = r;
        @(negedge clk);
        acc = v && in_ready;
        if (acc) begin
            it.mode = m;
            it.err  = (m == 2'd3);
            it.p    = model(m, x);
            it.acc  = cyc;
            it.lat  = lat_chk;
            exp_q.push_back(it);
            $display("issue mode=%0d x=%0d cyc=%0d", m, $signed(x), cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic [IN_W-1:0] x, input logic r);
        bit acc;
        int n;
        acc = 0;
        n = 0;
        while (!acc && n < 64) begin
            drive(1'b1, m, x, r, acc);
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected accept", n);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0, '0, 1'b1, acc);
    endtask

    // Monitor: scoreboard compare on every transfer, plus hold-stable check.
    logic          held_v;
    logic [PW-1:0] held_p;
    logic [1:0]    held_m;
    logic          held_e;

    initial held_v = 1'b0;

    always @(negedge clk) begin
        item_t it;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                chk("stall_valid", 256'(out_valid), 256'(1'b1));
                chk("stall_p", 256'(out_p), 256'(held_p));
                chk("stall_mode_err", 256'({out_mode, out_err}), 256'({held_m, held_e}));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got out_valid=1 expected no sample pending");
                end else begin
                    it = exp_q.pop_front();
                    chk("lanes", 256'(out_p), 256'(it.p));
                    chk("out_mode", 256'(out_mode), 256'(it.mode));
                    chk("out_err", 256'(out_err), 256'(it.err));
                    if (it.lat) chk("latency", 256'(cyc - it.acc), 256'(STAGES));
                    $display("emit mode=%0d err=%0d lane0=%0d lane7=%0d", out_mode, out_err,
                             $signed(out_p[0 +: OUT_W]), $signed(out_p[7*OUT_W +: OUT_W]));
                end
            end
            held_v = out_valid && !out_ready;
            held_p = out_p;
            held_m = out_mode;
            held_e = out_err;
        end
    end

    initial begin
        bit acc;
        int n;
        int sent;
        logic [IN_W-1:0] rx;

        rst = 1'b1;
        in_valid = 1'b0;
        in_mode = 2'd0;
        in_x = '0;
        out_ready = 1'b1;
        #1;
        chk("reset_out_valid", 256'(out_valid), 256'(1'b0));
        chk("reset_out_p", 256'(out_p), 256'(0));
        chk("reset_mode_err", 256'({out_mode, out_err}), 256'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 256'(in_ready), 256'(1'b1));
        @(posedge clk);
        #1;

        // Basic N16 products, x=1 and most-negative x
        lat_chk = 1;
        send(2'd2, 18'd1, 1'b1);
        idle(3);
        send(2'd2, 18'h20000, 1'b1);
        idle(3);

        // Back-to-back N8 then N4, no bubbles
        send(2'd1, 18'd100, 1'b1);
        send(2'd0, 18'd100, 1'b1);
        idle(3);

        // Reserved mode still flows with normal latency
        send(2'd3, 18'd5, 1'b1);
        idle(3);
        lat_chk = 0;

        // Backpressure: out_ready low for 3 cycles while streaming
        drive(1'b1, 2'd2, 18'd11, 1'b0, acc);
        chk("bp_accept0", 256'(acc), 256'(1'b1));
        drive(1'b1, 2'd1, 18'd22, 1'b0, acc);
        chk("bp_accept1", 256'(acc), 256'(1'b1));
        drive(1'b1, 2'd0, 18'd33, 1'b0, acc);
        chk("bp_full_ready", 256'(acc), 256'(1'b0));
        send(2'd0, 18'd33, 1'b1);
        send(2'd2, -18'sd44, 1'b1);
        idle(4);
        chk("bp_drained", 256'(exp_q.size()), 256'(0));

        // Reset with two samples in flight
        drive(1'b1, 2'd2, 18'd7, 1'b0, acc);
        drive(1'b1, 2'd2, 18'd8, 1'b0, acc);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midreset_out_valid", 256'(out_valid), 256'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        chk("post_reset_quiet", 256'(out_valid), 256'(1'b0));
        lat_chk = 1;
        send(2'd1, -18'sd3, 1'b1);
        idle(3);
        lat_chk = 0;

        // Randomized traffic
        sent = 0;
        n = 0;
        while (sent < 10000 && n < 40000) begin
            case ($urandom_range(0, 9))
                0:       rx = 18'h20000;
                1:       rx = 18'h1FFFF;
                default: rx = IN_W'($urandom);
            endcase
            drive(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), rx,
                  ($urandom_range(0, 9) < 7), acc);
            if (acc) sent++;
            n++;
        end
        chk("random_sent", 256'(sent), 256'(10000));

        // Drain
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        chk("final_drain", 256'(exp_q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sau_odd_pipe.md
Name: sau_odd_pipe

Overview:
- Pipelined, multi-mode shift-add multiplier bank for the odd half of the 1-D DCT-II.
- Each accepted sample is multiplied by the odd-coefficient set of the selected transform size (4, 8 or 16 point), using shared shift/add terms only (no `*` operators).
- Sits between the input butterfly and the odd-part accumulation adders.
- Uses a valid/ready handshake with full throughput and backpressure.

Parameters:
- IN_W, 18: signed input sample width.
- OUT_W, 27: signed product width per lane; must be >= IN_W+8.
- STAGES, 2: pipeline register stages, legal values 1 or 2.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- in_mode  in  2  transform size select: 0=N4, 1=N8, 2=N16, 3=reserved
- in_x  in  IN_W  signed sample
- out_valid  out  1  product vector valid
- out_ready  in  1  downstream accepts
- out_mode  out  2  in_mode that travelled with this sample
- out_err  out  1  high when the sample was issued with reserved mode 3
- out_p  out  8*OUT_W  8 signed lanes; lane k occupies bits [k*OUT_W +: OUT_W]

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - all stage valid bits cleared; out_valid=0.
  - out_p=0, out_mode=0, out_err=0.
  - in_ready=1 once reset deasserts.
- Coefficient map, lanes 0..7, ascending order:
  - mode 2 (N16): 9, 25, 43, 57, 70, 80, 87, 90.
  - mode 1 (N8): 18, 50, 75, 89, then lanes 4-7 = 0.
  - mode 0 (N4): 36, 83, then lanes 2-7 = 0.
  - mode 3: all lanes 0 and out_err=1; the sample still flows with normal latency.
- Arithmetic:
  - lane = exact signed product in_x*coef, sign-extended to OUT_W.
  - No rounding or saturation; |in_x|max*90 fits OUT_W by construction.
  - Unused lanes drive exactly 0.
- Pipeline with STAGES=2:
  - stage 1 registers the shared base terms x1, x4, x8, x9, x16, x32 (sign-extended), plus mode and valid.
  - stage 2 computes the final shift/adds and applies the per-mode lane mux into the output register.
- With STAGES=1, all logic sits before a single output register.
- Latency: STAGES cycles from an accepted input to out_valid.
- Handshake:
  - Transfer on in_valid&in_ready, and on out_valid&out_ready.
  - Stage i advances when its successor is empty or is advancing.
  - in_ready = !v1 | advance1, combinational from out_ready through the chain, with no registered ready.
  - Sustains one sample per cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, out_p, out_mode and out_err hold stable.
  - Pipeline bubbles collapse, so up to STAGES samples are buffered.
  - in_ready drops only when every stage is full.
- Simultaneous accept and emit in the same cycle is lossless and preserves order.
- Mode may change every sample; each sample carries its own mode through the pipeline.
- Reset mid-stream discards all in-flight samples; no partial output appears.
- in_x and in_mode are don't-care when in_valid=0; a valid bit is never set without in_valid.

Decomposition:
- Package dct_sau_pkg holds:
  - mode enum (MODE_N4, MODE_N8, MODE_N16, MODE_RSVD);
  - localparam coefficient arrays per mode, used by the bench only;
  - lane count constant NLANES=8.
- One natural sub-module, sau_odd_terms: combinational shared shift-add network from x to all 14 distinct products (9, 18, 25, 36, 43, 50, 57, 70, 75, 80, 83, 87, 89, 90).
  - The top holds the pipeline registers, handshake and lane mux.

Test Plan:
1. Reset, then mode 2, x=1, out_ready=1 → after 2 cycles, lanes = 9, 25, 43, 57, 70, 80, 87, 90; out_mode=2; out_err=0.
2. Mode 2, x=-131072 → lane7=-11796480, lane0=-1179648; sign extension to 27 bits is correct.
3. Back-to-back x=100 in mode 1, then mode 0 → lanes 18, 50, 75, 89 scaled: 1800, 5000, 7500, 8900, 0×4; then 3600, 8300, 0×6. Consecutive cycles, no bubbles.
4. Backpressure: 4 samples streaming with out_ready=0 for 3 cycles → in_ready falls after 2 accepts; held output stable; all 4 emerge in order with no loss or duplication.
5. Mode 3, x=5 → all lanes 0, out_err=1, latency 2.
6. Assert rst while 2 samples are in flight → out_valid=0 immediately; no stale sample appears after release; the first new sample has correct data.
7. Randomized mode, x and ready for 10k samples versus the package coefficient model: exact match on every lane.
